// File: rtl/aq_vidu_vid_wbt_fp_if.sv
// Dispatch, write-back and read-port bundle of the FP write-back table.
interface aq_vidu_vid_wbt_fp_if;
  logic       ctrl_wbt_fp_dis_inst_vld;
  logic       ctrl_wbt_fp_dis_inst_gateclk_vld;
  logic       dp_wbt_fp_dstf_vld;
  logic [4:0] dp_wbt_fp_dstf_reg;
  logic       dp_wbt_fp_wb_type;
  logic [4:0] dp_wbt_fp_srcf0_reg;
  logic [4:0] dp_wbt_fp_srcf1_reg;
  logic [4:0] dp_wbt_fp_srcf2_reg;
  logic [4:0] dp_wbt_fp_srcfm_reg;
  logic       vpu_vidu_fp_wb_vld;
  logic [4:0] vpu_vidu_fp_wb_reg;
  logic       lsu_vidu_fp_wb_vld;
  logic [4:0] lsu_vidu_fp_wb_reg;
  logic       rtu_vidu_wbt_flush;
  logic [2:0] wbt_ctrl_fp_srcv0_info;
  logic [2:0] wbt_ctrl_fp_srcv1_info;
  logic [2:0] wbt_ctrl_fp_srcv2_info;
  logic [2:0] wbt_ctrl_fp_srcvm_info;
  logic [2:0] wbt_ctrl_fp_dstv_info;
  logic       wbt_vidu_fp_empty;

  modport master (
    output ctrl_wbt_fp_dis_inst_vld,
    output ctrl_wbt_fp_dis_inst_gateclk_vld,
    output dp_wbt_fp_dstf_vld,
    output dp_wbt_fp_dstf_reg,
    output dp_wbt_fp_wb_type,
    output dp_wbt_fp_srcf0_reg,
    output dp_wbt_fp_srcf1_reg,
    output dp_wbt_fp_srcf2_reg,
    output dp_wbt_fp_srcfm_reg,
    output vpu_vidu_fp_wb_vld,
    output vpu_vidu_fp_wb_reg,
    output lsu_vidu_fp_wb_vld,
    output lsu_vidu_fp_wb_reg,
    output rtu_vidu_wbt_flush,
    input  wbt_ctrl_fp_srcv0_info,
    input  wbt_ctrl_fp_srcv1_info,
    input  wbt_ctrl_fp_srcv2_info,
    input  wbt_ctrl_fp_srcvm_info,
    input  wbt_ctrl_fp_dstv_info,
    input  wbt_vidu_fp_empty
  );

  modport slave (
    input  ctrl_wbt_fp_dis_inst_vld,
    input  ctrl_wbt_fp_dis_inst_gateclk_vld,
    input  dp_wbt_fp_dstf_vld,
    input  dp_wbt_fp_dstf_reg,
    input  dp_wbt_fp_wb_type,
    input  dp_wbt_fp_srcf0_reg,
    input  dp_wbt_fp_srcf1_reg,
    input  dp_wbt_fp_srcf2_reg,
    input  dp_wbt_fp_srcfm_reg,
    input  vpu_vidu_fp_wb_vld,
    input  vpu_vidu_fp_wb_reg,
    input  lsu_vidu_fp_wb_vld,
    input  lsu_vidu_fp_wb_reg,
    input  rtu_vidu_wbt_flush,
    output wbt_ctrl_fp_srcv0_info,
    output wbt_ctrl_fp_srcv1_info,
    output wbt_ctrl_fp_srcv2_info,
    output wbt_ctrl_fp_srcvm_info,
    output wbt_ctrl_fp_dstv_info,
    output wbt_vidu_fp_empty
  );
endinterface

// File: rtl/aq_vidu_vid_wbt_fp.sv
// FP write-back table: per-register {VLD,TYPE,CNT} producer tracking.
// Define VIDU_WBT_RD_BYPASS_EN to bypass same-cycle retires onto reads.
module aq_vidu_vid_wbt_fp (
  input logic                 forever_cpuclk,
  input logic                 cpurst_b,
  aq_vidu_vid_wbt_fp_if.slave wbt
);
  localparam int NUM_FREG = 32;
  localparam int INFO_W   = 3;

  logic [NUM_FREG-1:0] r_vld;
  logic [NUM_FREG-1:0] r_type;
  logic [NUM_FREG-1:0] r_cnt;

  logic                w_alloc;
  logic [NUM_FREG-1:0] w_alloc_hit;
  logic [NUM_FREG-1:0] w_alloc_ok;
  logic [NUM_FREG-1:0] w_vpu_hit;
  logic [NUM_FREG-1:0] w_lsu_hit;
  logic [NUM_FREG-1:0] w_en;
  logic [NUM_FREG-1:0] w_vld_n;
  logic [NUM_FREG-1:0] w_type_n;
  logic [NUM_FREG-1:0] w_cnt_n;
  logic [1:0]          w_pend_old [NUM_FREG];
  logic [1:0]          w_ret      [NUM_FREG];
  logic [1:0]          w_ret_eff  [NUM_FREG];
  logic [1:0]          w_pend_new [NUM_FREG];
  logic [1:0]          w_pend_rd  [NUM_FREG];
  logic [INFO_W-1:0]   w_info     [NUM_FREG];

  assign w_alloc = wbt.ctrl_wbt_fp_dis_inst_vld
                 & wbt.dp_wbt_fp_dstf_vld;

  // Work in pending counts; retires beyond what is pending are dropped.
  always_comb begin
    for (int i = 0; i < NUM_FREG; i++) begin
      w_alloc_hit[i] = w_alloc
        && (wbt.dp_wbt_fp_dstf_reg == 5'(i));
      w_vpu_hit[i] = wbt.vpu_vidu_fp_wb_vld
        && (wbt.vpu_vidu_fp_wb_reg == 5'(i));
      w_lsu_hit[i] = wbt.lsu_vidu_fp_wb_vld
        && (wbt.lsu_vidu_fp_wb_reg == 5'(i));
      w_pend_old[i] = r_vld[i] ? 2'd0
                    : (r_cnt[i] ? 2'd2 : 2'd1);
      w_ret[i] = {1'b0, w_vpu_hit[i]}
               + {1'b0, w_lsu_hit[i]};
      w_ret_eff[i] = (w_ret[i] > w_pend_old[i])
                   ? w_pend_old[i] : w_ret[i];
      w_alloc_ok[i] = w_alloc_hit[i]
                    && (w_pend_old[i] != 2'd2);
      w_pend_new[i] = w_pend_old[i]
                    + {1'b0, w_alloc_ok[i]}
                    - w_ret_eff[i];
      w_vld_n[i] = (w_pend_new[i] == 2'd0);
      w_cnt_n[i] = (w_pend_new[i] == 2'd2);
      w_type_n[i] = (w_alloc_ok[i]
        && ((w_pend_old[i] == 2'd0) || (w_ret[i] != 2'd0)))
        ? wbt.dp_wbt_fp_wb_type : r_type[i];
      w_en[i] = wbt.rtu_vidu_wbt_flush
        | (wbt.ctrl_wbt_fp_dis_inst_gateclk_vld
           && wbt.dp_wbt_fp_dstf_vld
           && (wbt.dp_wbt_fp_dstf_reg == 5'(i)))
        | w_vpu_hit[i] | w_lsu_hit[i];
`ifdef VIDU_WBT_RD_BYPASS_EN
      w_pend_rd[i] = w_pend_old[i] - w_ret_eff[i];
`else
      w_pend_rd[i] = w_pend_old[i];
`endif
      w_info[i] = {w_pend_rd[i] == 2'd0, r_type[i],
                   w_pend_rd[i] == 2'd2};
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_vld  <= '1;
      r_type <= '0;
      r_cnt  <= '0;
    end else if (wbt.rtu_vidu_wbt_flush) begin
      r_vld  <= '1;
      r_type <= '0;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_FREG; i++) begin
        if (w_en[i]) begin
          r_vld[i]  <= w_vld_n[i];
          r_type[i] <= w_type_n[i];
          r_cnt[i]  <= w_cnt_n[i];
        end
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b && !wbt.rtu_vidu_wbt_flush) begin
      for (int i = 0; i < NUM_FREG; i++) begin
        assert (!(w_alloc_hit[i] && w_pend_old[i] == 2'd2));
        assert (!((w_ret[i] != 2'd0) && r_vld[i]));
      end
    end
  end

  assign wbt.wbt_ctrl_fp_srcv0_info = w_info[wbt.dp_wbt_fp_srcf0_reg];
  assign wbt.wbt_ctrl_fp_srcv1_info = w_info[wbt.dp_wbt_fp_srcf1_reg];
  assign wbt.wbt_ctrl_fp_srcv2_info = w_info[wbt.dp_wbt_fp_srcf2_reg];
  assign wbt.wbt_ctrl_fp_srcvm_info = w_info[wbt.dp_wbt_fp_srcfm_reg];
  assign wbt.wbt_ctrl_fp_dstv_info  = w_info[wbt.dp_wbt_fp_dstf_reg];
  assign wbt.wbt_vidu_fp_empty      = &r_vld;
endmodule

// File: tb/tb_aq_vidu_vid_wbt_fp.sv
// Bench for the FP write-back table: directed plan steps plus
// random legal traffic against a pending-count reference model.
module tb_aq_vidu_vid_wbt_fp;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pend [32];
  bit   typ  [32];

  aq_vidu_vid_wbt_fp_if bus ();

  aq_vidu_vid_wbt_fp dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .wbt            (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [2:0] obs,
                     input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ctrl_wbt_fp_dis_inst_vld = 1'b0;
    bus.ctrl_wbt_fp_dis_inst_gateclk_vld = 1'b0;
    bus.dp_wbt_fp_dstf_vld = 1'b0;
    bus.dp_wbt_fp_wb_type = 1'b0;
    bus.vpu_vidu_fp_wb_vld = 1'b0;
    bus.lsu_vidu_fp_wb_vld = 1'b0;
    bus.rtu_vidu_wbt_flush = 1'b0;
  endtask

  task automatic alloc(input int r, input bit t);
    bus.ctrl_wbt_fp_dis_inst_vld = 1'b1;
    bus.ctrl_wbt_fp_dis_inst_gateclk_vld = 1'b1;
    bus.dp_wbt_fp_dstf_vld = 1'b1;
    bus.dp_wbt_fp_dstf_reg = 5'(r);
    bus.dp_wbt_fp_wb_type = t;
  endtask

  function automatic int hits(input int a);
    int n;
    n = 0;
    if (bus.vpu_vidu_fp_wb_vld && bus.vpu_vidu_fp_wb_reg == 5'(a)) n++;
    if (bus.lsu_vidu_fp_wb_vld && bus.lsu_vidu_fp_wb_reg == 5'(a)) n++;
    return n;
  endfunction

  function automatic logic [2:0] exp_info(input logic [4:0] a);
    int p;
    p = pend[a];
`ifdef VIDU_WBT_RD_BYPASS_EN
    p = p - ((hits(a) > p) ? p : hits(a));
`endif
    return {p == 0, typ[a], p == 2};
  endfunction

  function automatic logic [2:0] exp_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < 32; i++) if (pend[i] != 0) e = 1'b0;
    return {2'b00, e};
  endfunction

  task automatic check_outs();
    chk("src0", bus.wbt_ctrl_fp_srcv0_info, exp_info(bus.dp_wbt_fp_srcf0_reg));
    chk("src1", bus.wbt_ctrl_fp_srcv1_info, exp_info(bus.dp_wbt_fp_srcf1_reg));
    chk("src2", bus.wbt_ctrl_fp_srcv2_info, exp_info(bus.dp_wbt_fp_srcf2_reg));
    chk("srcm", bus.wbt_ctrl_fp_srcvm_info, exp_info(bus.dp_wbt_fp_srcfm_reg));
    chk("dstv", bus.wbt_ctrl_fp_dstv_info, exp_info(bus.dp_wbt_fp_dstf_reg));
    chk("empty", {2'b00, bus.wbt_vidu_fp_empty}, exp_empty());
  endtask

  task automatic model_update();
    int  ret, re, np;
    bit  a;
    if (bus.rtu_vidu_wbt_flush) begin
      for (int i = 0; i < 32; i++) begin
        pend[i] = 0;
        typ[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        ret = hits(i);
        a = bus.ctrl_wbt_fp_dis_inst_vld && bus.dp_wbt_fp_dstf_vld
            && bus.dp_wbt_fp_dstf_reg == 5'(i) && pend[i] < 2;
        re = (ret > pend[i]) ? pend[i] : ret;
        np = pend[i] + int'(a) - re;
        if (a && (pend[i] == 0 || ret > 0)) typ[i] = bus.dp_wbt_fp_wb_type;
        pend[i] = np;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_outs();
    @(posedge clk);
    model_update();
    #1;
    idle();
  endtask

  task automatic reads(input int a0, input int a1, input int a2,
                       input int am, input int ad);
    bus.dp_wbt_fp_srcf0_reg = 5'(a0);
    bus.dp_wbt_fp_srcf1_reg = 5'(a1);
    bus.dp_wbt_fp_srcf2_reg = 5'(a2);
    bus.dp_wbt_fp_srcfm_reg = 5'(am);
    bus.dp_wbt_fp_dstf_reg  = 5'(ad);
  endtask

  initial begin
    int r, r2;
    bit t;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) begin
      pend[i] = 0;
      typ[i] = 1'b0;
    end
    idle();
    reads(0, 1, 2, 3, 4);
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    #1;
    chk("rst_src0", bus.wbt_ctrl_fp_srcv0_info, 3'b100);
    chk("rst_src1", bus.wbt_ctrl_fp_srcv1_info, 3'b100);
    chk("rst_src2", bus.wbt_ctrl_fp_srcv2_info, 3'b100);
    chk("rst_srcm", bus.wbt_ctrl_fp_srcvm_info, 3'b100);
    chk("rst_dstv", bus.wbt_ctrl_fp_dstv_info, 3'b100);
    chk("rst_empty", {2'b00, bus.wbt_vidu_fp_empty}, 3'b001);
    @(posedge clk);
    #1;

    reads(3, 0, 0, 0, 3);
    alloc(3, 1'b0);
    tick();
    #1;
    chk("f3_c1", bus.wbt_ctrl_fp_dstv_info, 3'b000);
    chk("f3_empty0", {2'b00, bus.wbt_vidu_fp_empty}, 3'b000);
    tick();
    #1;
    chk("f3_c2", bus.wbt_ctrl_fp_dstv_info, 3'b000);
    bus.vpu_vidu_fp_wb_vld = 1'b1;
    bus.vpu_vidu_fp_wb_reg = 5'd3;
    tick();
    #1;
    chk("f3_done", bus.wbt_ctrl_fp_dstv_info, 3'b100);
    chk("f3_empty1", {2'b00, bus.wbt_vidu_fp_empty}, 3'b001);

    reads(5, 0, 0, 0, 5);
    alloc(5, 1'b1);
    tick();
    #1 chk("f5_p1", bus.wbt_ctrl_fp_srcv0_info, 3'b010);
    alloc(5, 1'b1);
    tick();
    #1 chk("f5_p2", bus.wbt_ctrl_fp_srcv0_info, 3'b011);
    bus.lsu_vidu_fp_wb_vld = 1'b1;
    bus.lsu_vidu_fp_wb_reg = 5'd5;
    tick();
    #1 chk("f5_wb1", bus.wbt_ctrl_fp_srcv0_info, 3'b010);
    bus.lsu_vidu_fp_wb_vld = 1'b1;
    bus.lsu_vidu_fp_wb_reg = 5'd5;
    tick();
    #1 chk("f5_wb2", bus.wbt_ctrl_fp_srcv0_info, 3'b110);

    reads(7, 9, 0, 0, 7);
    alloc(7, 1'b1);
    tick();
    alloc(7, 1'b0);
    bus.lsu_vidu_fp_wb_vld = 1'b1;
    bus.lsu_vidu_fp_wb_reg = 5'd7;
    tick();
    #1 chk("f7_swap", bus.wbt_ctrl_fp_srcv0_info, 3'b000);
    alloc(9, 1'b1);
    tick();
    alloc(9, 1'b1);
    tick();
    bus.vpu_vidu_fp_wb_vld = 1'b1;
    bus.vpu_vidu_fp_wb_reg = 5'd9;
    bus.lsu_vidu_fp_wb_vld = 1'b1;
    bus.lsu_vidu_fp_wb_reg = 5'd9;
    tick();
    #1 chk("f9_dual", bus.wbt_ctrl_fp_srcv1_info, 3'b110);
    bus.vpu_vidu_fp_wb_vld = 1'b1;
    bus.vpu_vidu_fp_wb_reg = 5'd7;
    tick();

    alloc(1, 1'b1);
    tick();
    alloc(2, 1'b0);
    tick();
    alloc(31, 1'b1);
    tick();
    alloc(4, 1'b1);
    bus.rtu_vidu_wbt_flush = 1'b1;
    tick();
    reads(1, 2, 31, 4, 7);
    #1;
    chk("fl_f1", bus.wbt_ctrl_fp_srcv0_info, 3'b100);
    chk("fl_f2", bus.wbt_ctrl_fp_srcv1_info, 3'b100);
    chk("fl_f31", bus.wbt_ctrl_fp_srcv2_info, 3'b100);
    chk("fl_f4", bus.wbt_ctrl_fp_srcvm_info, 3'b100);
    chk("fl_f7", bus.wbt_ctrl_fp_dstv_info, 3'b100);
    chk("fl_empty", {2'b00, bus.wbt_vidu_fp_empty}, 3'b001);

    reads(0, 6, 0, 0, 6);
    alloc(6, 1'b0);
    tick();
    bus.vpu_vidu_fp_wb_vld = 1'b1;
    bus.vpu_vidu_fp_wb_reg = 5'd6;
    #1;
`ifdef VIDU_WBT_RD_BYPASS_EN
    chk("f6_same", bus.wbt_ctrl_fp_srcv1_info, 3'b100);
`else
    chk("f6_same", bus.wbt_ctrl_fp_srcv1_info, 3'b000);
`endif
    tick();
    #1 chk("f6_next", bus.wbt_ctrl_fp_srcv1_info, 3'b100);

    for (int n = 0; n < 400; n++) begin
      reads($urandom % 32, $urandom % 32, $urandom % 32,
            $urandom % 32, $urandom % 32);
      r = $urandom % 32;
      t = 1'($urandom % 2);
      if ($urandom_range(0, 2) == 0 && (pend[r] == 0 || (pend[r] == 1 && typ[r]))) begin
        if (pend[r] == 1) t = 1'b1;
        alloc(r, t);
      end else begin
        bus.dp_wbt_fp_dstf_vld = 1'($urandom % 2);
        bus.ctrl_wbt_fp_dis_inst_gateclk_vld = 1'($urandom % 2);
      end
      r2 = $urandom % 32;
      if (pend[r2] > 0 && $urandom % 2 == 1) begin
        bus.vpu_vidu_fp_wb_vld = 1'b1;
        bus.vpu_vidu_fp_wb_reg = 5'(r2);
      end
      r2 = $urandom % 32;
      if (pend[r2] > 0 && $urandom % 2 == 1) begin
        bus.lsu_vidu_fp_wb_vld = 1'b1;
        bus.lsu_vidu_fp_wb_reg = 5'(r2);
      end
      if ($urandom % 40 == 0) bus.rtu_vidu_wbt_flush = 1'b1;
      tick();
    end

    idle();
    if (pend[10] == 0) alloc(10, 1'b0);
    tick();
    reads(10, 0, 0, 0, 10);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      pend[i] = 0;
      typ[i] = 1'b0;
    end
    chk("arst_f10", bus.wbt_ctrl_fp_srcv0_info, 3'b100);
    chk("arst_empty", {2'b00, bus.wbt_vidu_fp_empty}, 3'b001);
    #1 rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aq_vidu_vid_wbt_fp.md
Name: aq_vidu_vid_wbt_fp

Overview:
- Write-back table (scoreboard) for the 32 FP registers. Sits directly upstream of the VIDU FP dispatch control.
- Per register it tracks outstanding producers as {VLD, TYPE, CNT}.
- Allocates an entry when an FP/vec-reuse instruction with a destination dispatches; retires it on VFPU or LSU write-back.
- Serves combinational read ports that the dispatch control uses for RAW/WAW stall decisions.

Parameters:
- NUM_FREG, 32, number of FP architectural registers (index width 5).
- INFO_W, 3, width of each info bus: [2]=VLD (no outstanding producer), [1]=TYPE (1=VLSU, 0=VFPU), [0]=CNT (0=one outstanding, 1=two outstanding).

Ports:
- forever_cpuclk  in  1  core clock.
- cpurst_b  in  1  asynchronous active-low reset.
- ctrl_wbt_fp_dis_inst_vld  in  1  dispatch/reuse instruction pipes down this cycle.
- ctrl_wbt_fp_dis_inst_gateclk_vld  in  1  clock-enable companion of dis_inst_vld.
- dp_wbt_fp_dstf_vld  in  1  dispatched instruction writes an FP register.
- dp_wbt_fp_dstf_reg  in  5  destination register.
- dp_wbt_fp_wb_type  in  1  producer type (1=VLSU).
- dp_wbt_fp_srcf0_reg / srcf1_reg / srcf2_reg / srcfm_reg  in  5 each  read addresses.
- vpu_vidu_fp_wb_vld  in  1  VFPU write-back this cycle.
- vpu_vidu_fp_wb_reg  in  5  VFPU write-back register.
- lsu_vidu_fp_wb_vld  in  1  LSU FP load write-back this cycle.
- lsu_vidu_fp_wb_reg  in  5  LSU write-back register.
- rtu_vidu_wbt_flush  in  1  all in-flight producers killed; table cleared.
- wbt_ctrl_fp_srcv0_info / srcv1_info / srcv2_info / srcvm_info  out  3 each  info at the source addresses.
- wbt_ctrl_fp_dstv_info  out  3  info at dp_wbt_fp_dstf_reg.
- wbt_vidu_fp_empty  out  1  every entry has VLD=1.

Behaviour:
- Reset: all entries go to VLD=1, TYPE=0, CNT=0. Therefore all info outputs read 3'b100 and wbt_vidu_fp_empty=1.
- Allocation: alloc = dis_inst_vld && dstf_vld, applied at the clock edge.
  - Entry with VLD=1: becomes VLD=0, TYPE=wb_type, CNT=0.
  - Entry with VLD=0, CNT=0: becomes CNT=1; TYPE is unchanged. Upstream only permits this when both old and new producers are VLSU.
  - Entry with VLD=0, CNT=1: alloc is illegal and flagged by an assertion; state is unchanged.
- Write-back: each wb port that hits an entry counts as one retire.
  - Entry state is reduced to a pending count: 0 if VLD=1, else CNT+1. The new pending count is old pending + alloc − retires.
  - VFPU and LSU hitting the same entry in one cycle is two retires.
  - New pending 0 gives VLD=1, CNT=0, TYPE unchanged. Pending 1 gives VLD=0, CNT=0. Pending 2 gives VLD=0, CNT=1.
  - A retire on an entry with VLD=1 is ignored (floor at 0) and asserted.
- Same-cycle alloc and retire on one register: alloc takes TYPE. Example: pending 1 + alloc + 1 retire gives pending 1 with the new TYPE.
- Flush: rtu_vidu_wbt_flush sets all entries to the reset value next cycle and overrides any same-cycle alloc or retire.
- Reads are combinational from registered state, with zero latency. Multiple read ports may address the same entry.
- wbt_vidu_fp_empty is the AND of all VLD bits from registered state.
- Entry update is enabled by (gateclk_vld && dstf_vld) || either wb_vld || flush, per entry via address decode. No state changes otherwise.
- Reset asserted mid-operation clears state asynchronously, independent of the clock.

Optional Feature:
- VIDU_WBT_RD_BYPASS_EN defined: info outputs bypass same-cycle write-backs.
  - If the addressed entry has pending 1 and a retire hits it this cycle, output VLD=1.
  - If pending 2 with one retire, output CNT=0.
- wbt_vidu_fp_empty is not bypassed.
- Not defined: outputs reflect registered state only, and a retire becomes visible one cycle later.

Test Plan:
1. Reset release → all five info outputs = 3'b100, empty=1.
2. Alloc f3 VFPU (type 0), then VFPU wb f3 two cycles later → dstv_info at f3 = 3'b000 for two cycles, then 3'b100; empty goes 0 then 1.
3. Alloc f5 VLSU, alloc f5 VLSU again, then LSU wb f5 twice → srcv0_info(f5) = 3'b010, 3'b011, 3'b010, 3'b110.
4. f7 pending 1 VLSU; same cycle alloc f7 VFPU plus LSU wb f7 → next cycle info(f7)=3'b000. Same cycle VFPU wb f9 and LSU wb f9 with f9 at pending 2 → info(f9)=3'b110.
5. Allocs pending on f1, f2, f31 with flush asserted together with a new alloc f4 → next cycle all entries 3'b100, empty=1.
6. With VIDU_WBT_RD_BYPASS_EN: f6 pending 1, VFPU wb f6 → srcv1_info(f6)=3'b100 in the same cycle. Without the macro → 3'b000 that cycle, 3'b100 the next.
